price_level_book: RTL and testbench
===================================

# price_level_book

Parametrised multi-level successor to the single-level BBO tracker. It keeps the top DEPTH aggregated price levels per side (price plus total quantity) and supports add, reduce and clear operations. It exposes the full sorted ladders and the best level of each side. It sits between the feed parser and the strategy/ILA, and accepts one tick at a time through a valid/ready handshake.

## Interface
- PRICE_W, 32, price width (unsigned integer ticks)
- QTY_W, 32, quantity width (unsigned)
- DEPTH, 4, levels per side (2..16)
- CNT_W, 16, width of drop counter
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_tick_price  in  PRICE_W  level price
- s_tick_qty  in  QTY_W  quantity delta
- s_tick_is_buy  in  1  1 = bid side, 0 = ask side
- s_tick_op  in  2  00 ADD, 01 REDUCE, 10 CLEAR side, 11 reserved
- s_tick_valid  in  1  tick present
- s_tick_ready  out  1  block can accept a tick this cycle
- bid_prices / bid_qtys  out  DEPTH*PRICE_W / DEPTH*QTY_W  bid ladder, slot 0 in LSBs, descending price
- ask_prices / ask_qtys  out  DEPTH*PRICE_W / DEPTH*QTY_W  ask ladder, slot 0 in LSBs, ascending price
- bid_count, ask_count  out  $clog2(DEPTH+1)  occupied levels
- best_bid, best_ask  out  PRICE_W  slot 0 prices
- best_bid_qty, best_ask_qty  out  QTY_W  slot 0 quantities
- bbo_updated  out  1  one-cycle pulse when slot 0 price or qty of either side changes
- drop_count  out  CNT_W  saturating count of rejected ticks

## Operation
- Empty slot sentinel: bid price 0, ask price all-ones, qty 0. Occupied slots are contiguous from slot 0 and strictly ordered (no duplicate prices).
- FSM has three states: IDLE -> MATCH -> APPLY -> IDLE. s_tick_ready = 1 only in IDLE. A tick is accepted on the edge where valid && ready; its fields are registered.
- MATCH: compare the captured price against all DEPTH slots of the selected side in parallel. Register three results: hit flag with its index, insert index (first slot the new price beats), and side-full flag.
- APPLY, per opcode:
  - ADD, hit: qty += s_tick_qty, saturating at all-ones.
  - ADD, miss, insert index < DEPTH: shift slots insert..DEPTH-2 down by one, write the new level, and increment count unless the side is full (the worst level falls off).
  - ADD, miss, price worse than a full side's worst level: drop.
  - REDUCE, hit: qty -= min(qty, s_tick_qty). If the result is 0, remove the level, shift the slots below up, fill the last slot with the sentinel, and decrement count.
  - REDUCE, miss: drop.
  - CLEAR: all slots of that side go to sentinel and count goes to 0. Price and qty are ignored.
  - Reserved opcode: drop.
- Rejected on accept regardless of opcode (except CLEAR): price 0, qty 0, or ask price all-ones. Such ticks still go through the FSM and are counted as drops; the book is unchanged.
- Each drop increments drop_count, saturating at all-ones.
- bbo_updated = 1 in the cycle after APPLY iff the best price or best qty of the touched side differs from its pre-APPLY value. A CLEAR of an empty side does not pulse.

## Timing
- Reset values: all ladders at sentinel, counts 0, best_bid 0, best_ask all-ones, best quantities 0, bbo_updated 0, drop_count 0, state IDLE, s_tick_ready 1.
- Accept at edge E0. MATCH results are registered at E1. Ladder, count and best outputs update at E2. bbo_updated is high for the cycle E2..E3. s_tick_ready returns to 1 after E2.
- Latency is 2 cycles; throughput is 1 tick per 3 cycles. A valid held while ready = 0 is not consumed and must remain stable.
- All outputs are registered; none depends combinationally on inputs, except that s_tick_ready depends on state only.
- Asserting rst_n low at any point, including mid-MATCH/APPLY, discards the in-flight tick and forces all reset values immediately. No partial update survives.

## Test plan
- Reset then ADD bid 15000/100, ADD bid 15010/50, ADD bid 14990/20 -> bid_prices 15010,15000,14990, bid_qtys 50,100,20, bid_count 3; bbo_updated pulses after the first two only.
- DEPTH=4 with asks 100,101,102,103, then ADD ask 99/7 -> asks 99,100,101,102, count stays 4, best_ask 99, pulse. Then ADD ask 200/1 -> no change, drop_count 1.
- ADD bid 15000/100 twice -> single level, qty 200. REDUCE 15000/250 -> level removed, best_bid 0, qty 0, count 0, pulse.
- ADD with qty all-ones onto an existing level of qty 5 -> qty saturates at all-ones. REDUCE on an absent price, a price 0 tick and op 11 -> drop_count +3, book unchanged, no pulse.
- Hold s_tick_valid high for 9 back-to-back ticks -> exactly 3 accepted per 9 cycles, ready pattern 1,0,0 repeating, each result visible 2 cycles after its accept.
- Accept ADD bid 500/1, then pull rst_n low in the MATCH cycle -> all reset values, bid_count 0, no bbo_updated pulse after release.

Source files
------------

// File: rtl/price_level_book_if.sv
// Tick input bundle for price_level_book: one price-level update per valid/ready handshake.
interface price_level_book_if #(
    parameter int unsigned PRICE_W = 32,
    parameter int unsigned QTY_W   = 32
);
    logic [PRICE_W-1:0] s_tick_price;
    logic [QTY_W-1:0]   s_tick_qty;
    logic               s_tick_is_buy;
    logic [1:0]         s_tick_op;
    logic               s_tick_valid;
    logic               s_tick_ready;

    modport master (
        output s_tick_price, s_tick_qty, s_tick_is_buy, s_tick_op, s_tick_valid,
        input  s_tick_ready
    );

    modport slave (
        input  s_tick_price, s_tick_qty, s_tick_is_buy, s_tick_op, s_tick_valid,
        output s_tick_ready
    );
endinterface

// File: rtl/price_level_book.sv
// Top-DEPTH aggregated price ladder per side with add/reduce/clear, processed as
// a three-state IDLE -> MATCH -> APPLY pipeline (one tick per three cycles).
module price_level_book #(
    parameter int unsigned PRICE_W = 32,
    parameter int unsigned QTY_W   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    price_level_book_if.slave          s_tick,
    output logic [DEPTH*PRICE_W-1:0]   bid_prices,
    output logic [DEPTH*QTY_W-1:0]     bid_qtys,
    output logic [DEPTH*PRICE_W-1:0]   ask_prices,
    output logic [DEPTH*QTY_W-1:0]     ask_qtys,
    output logic [$clog2(DEPTH+1)-1:0] bid_count,
    output logic [$clog2(DEPTH+1)-1:0] ask_count,
    output logic [PRICE_W-1:0]         best_bid,
    output logic [PRICE_W-1:0]         best_ask,
    output logic [QTY_W-1:0]           best_bid_qty,
    output logic [QTY_W-1:0]           best_ask_qty,
    output logic                       bbo_updated,
    output logic [CNT_W-1:0]           drop_count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [1:0] OpAdd    = 2'b00;
    localparam logic [1:0] OpReduce = 2'b01;
    localparam logic [1:0] OpClear  = 2'b10;

    typedef enum logic [1:0] {StIdle, StMatch, StApply} state_e;
    state_e r_state, w_state_nxt;

    logic [PRICE_W-1:0] r_bid_p [DEPTH];
    logic [QTY_W-1:0]   r_bid_q [DEPTH];
    logic [PRICE_W-1:0] r_ask_p [DEPTH];
    logic [QTY_W-1:0]   r_ask_q [DEPTH];
    logic [CW-1:0]      r_bid_cnt, r_ask_cnt;

    logic [PRICE_W-1:0] r_price;
    logic [QTY_W-1:0]   r_qty;
    logic               r_is_buy;
    logic [1:0]         r_op;
    logic               r_reject;

    logic               r_hit, w_hit;
    logic [IW-1:0]      r_hit_idx, w_hit_idx;
    logic [CW-1:0]      r_ins_idx, w_ins_idx;
    logic               r_full;

    logic               r_bbo_upd;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic [PRICE_W-1:0] w_sel_p [DEPTH];
    logic [QTY_W-1:0]   w_sel_q [DEPTH];
    logic [CW-1:0]      w_sel_cnt;
    logic [PRICE_W-1:0] w_sent_p;
    logic [PRICE_W-1:0] w_new_p [DEPTH];
    logic [QTY_W-1:0]   w_new_q [DEPTH];
    logic [CW-1:0]      w_new_cnt;
    logic               w_drop;
    logic [QTY_W:0]     w_sum;
    logic               w_accept;

    assign w_accept            = (r_state == StIdle) && s_tick.s_tick_valid;
    assign s_tick.s_tick_ready = (r_state == StIdle);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (s_tick.s_tick_valid) w_state_nxt = StMatch;
            StMatch: w_state_nxt = StApply;
            StApply: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_sel_p[i] = r_is_buy ? r_bid_p[i] : r_ask_p[i];
            w_sel_q[i] = r_is_buy ? r_bid_q[i] : r_ask_q[i];
        end
        w_sel_cnt = r_is_buy ? r_bid_cnt : r_ask_cnt;
        w_sent_p  = r_is_buy ? '0 : '1;
    end

    // Descending scan so the lowest matching slot wins for the insert index.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_ins_idx = CW'(DEPTH);
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (i < int'(w_sel_cnt)) begin
                if (w_sel_p[i] == r_price) begin
                    w_hit     = 1'b1;
                    w_hit_idx = IW'(i);
                end
                if (r_is_buy ? (r_price > w_sel_p[i]) : (r_price < w_sel_p[i])) begin
                    w_ins_idx = CW'(i);
                end
            end else begin
                w_ins_idx = CW'(i);
            end
        end
    end

    assign w_sum = {1'b0, w_sel_q[r_hit_idx]} + {1'b0, r_qty};

    always_comb begin
        w_new_p   = w_sel_p;
        w_new_q   = w_sel_q;
        w_new_cnt = w_sel_cnt;
        w_drop    = 1'b0;
        if (r_reject) begin
            w_drop = 1'b1;
        end else begin
            unique case (r_op)
                OpAdd: begin
                    if (r_hit) begin
                        w_new_q[r_hit_idx] = w_sum[QTY_W] ? '1 : w_sum[QTY_W-1:0];
                    end else if (int'(r_ins_idx) < int'(DEPTH)) begin
                        for (int i = 1; i < int'(DEPTH); i++) begin
                            if (i > int'(r_ins_idx)) begin
                                w_new_p[i] = w_sel_p[i-1];
                                w_new_q[i] = w_sel_q[i-1];
                            end
                        end
                        w_new_p[r_ins_idx[IW-1:0]] = r_price;
                        w_new_q[r_ins_idx[IW-1:0]] = r_qty;
                        if (!r_full) w_new_cnt = w_sel_cnt + CW'(1);
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                OpReduce: begin
                    if (!r_hit) begin
                        w_drop = 1'b1;
                    end else if (w_sel_q[r_hit_idx] > r_qty) begin
                        w_new_q[r_hit_idx] = w_sel_q[r_hit_idx] - r_qty;
                    end else begin
                        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                            if (i >= int'(r_hit_idx)) begin
                                w_new_p[i] = w_sel_p[i+1];
                                w_new_q[i] = w_sel_q[i+1];
                            end
                        end
                        w_new_p[DEPTH-1] = w_sent_p;
                        w_new_q[DEPTH-1] = '0;
                        w_new_cnt        = w_sel_cnt - CW'(1);
                    end
                end
                OpClear: begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        w_new_p[i] = w_sent_p;
                        w_new_q[i] = '0;
                    end
                    w_new_cnt = '0;
                end
                default: w_drop = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_bid_p[i] <= '0;
                r_bid_q[i] <= '0;
                r_ask_p[i] <= '1;
                r_ask_q[i] <= '0;
            end
            r_bid_cnt  <= '0;
            r_ask_cnt  <= '0;
            r_price    <= '0;
            r_qty      <= '0;
            r_is_buy   <= 1'b0;
            r_op       <= 2'b00;
            r_reject   <= 1'b0;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
            r_ins_idx  <= '0;
            r_full     <= 1'b0;
            r_bbo_upd  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bbo_upd <= 1'b0;
            if (w_accept) begin
                r_price  <= s_tick.s_tick_price;
                r_qty    <= s_tick.s_tick_qty;
                r_is_buy <= s_tick.s_tick_is_buy;
                r_op     <= s_tick.s_tick_op;
                r_reject <= (s_tick.s_tick_op != OpClear) &&
                            ((s_tick.s_tick_price == '0) || (s_tick.s_tick_qty == '0) ||
                             (!s_tick.s_tick_is_buy && (s_tick.s_tick_price == '1)));
            end
            if (r_state == StMatch) begin
                r_hit     <= w_hit;
                r_hit_idx <= w_hit_idx;
                r_ins_idx <= w_ins_idx;
                r_full    <= (w_sel_cnt == CW'(DEPTH));
            end
            if (r_state == StApply) begin
                if (r_is_buy) begin
                    r_bid_p   <= w_new_p;
                    r_bid_q   <= w_new_q;
                    r_bid_cnt <= w_new_cnt;
                end else begin
                    r_ask_p   <= w_new_p;
                    r_ask_q   <= w_new_q;
                    r_ask_cnt <= w_new_cnt;
                end
                r_bbo_upd <= (w_new_p[0] != w_sel_p[0]) || (w_new_q[0] != w_sel_q[0]);
                if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flat
        assign bid_prices[g*PRICE_W +: PRICE_W] = r_bid_p[g];
        assign bid_qtys[g*QTY_W +: QTY_W]       = r_bid_q[g];
        assign ask_prices[g*PRICE_W +: PRICE_W] = r_ask_p[g];
        assign ask_qtys[g*QTY_W +: QTY_W]       = r_ask_q[g];
    end

    assign bid_count    = r_bid_cnt;
    assign ask_count    = r_ask_cnt;
    assign best_bid     = r_bid_p[0];
    assign best_ask     = r_ask_p[0];
    assign best_bid_qty = r_bid_q[0];
    assign best_ask_qty = r_ask_q[0];
    assign bbo_updated  = r_bbo_upd;
    assign drop_count   = r_drop_cnt;
endmodule

// File: tb/tb_price_level_book.sv
// Directed self-checking bench for price_level_book (DEPTH=4, 32-bit fields).
module tb_price_level_book;
    logic clk;
    logic rst_n;

    logic [127:0] bid_prices, bid_qtys, ask_prices, ask_qtys;
    logic [2:0]   bid_count, ask_count;
    logic [31:0]  best_bid, best_ask, best_bid_qty, best_ask_qty;
    logic         bbo_updated;
    logic [15:0]  drop_count;

    int n_total = 0;
    int n_bad   = 0;

    price_level_book_if #(.PRICE_W(32), .QTY_W(32)) tick_if ();

    price_level_book #(.PRICE_W(32), .QTY_W(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_tick       (tick_if.slave),
        .bid_prices   (bid_prices),
        .bid_qtys     (bid_qtys),
        .ask_prices   (ask_prices),
        .ask_qtys     (ask_qtys),
        .bid_count    (bid_count),
        .ask_count    (ask_count),
        .best_bid     (best_bid),
        .best_ask     (best_ask),
        .best_bid_qty (best_bid_qty),
        .best_ask_qty (best_ask_qty),
        .bbo_updated  (bbo_updated),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one tick and return the bbo_updated value seen in the cycle after APPLY.
    task automatic do_tick(input logic [31:0] p, input logic [31:0] q, input logic buy,
                           input logic [1:0] op, output logic pulse);
        int w;
        w = 0;
        tick_if.s_tick_price  = p;
        tick_if.s_tick_qty    = q;
        tick_if.s_tick_is_buy = buy;
        tick_if.s_tick_op     = op;
        tick_if.s_tick_valid  = 1'b1;
        while (tick_if.s_tick_ready !== 1'b1 && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 10) begin
            n_total++; n_bad++;
            $display("FAIL ready_timeout got ready=%b want 1", tick_if.s_tick_ready);
        end
        @(posedge clk); #1;
        tick_if.s_tick_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulse = bbo_updated;
    endtask

    task automatic test_reset();
        n_total++;
        if (bid_count !== 3'd0 || ask_count !== 3'd0) begin
            n_bad++; $display("FAIL reset_counts got %0d/%0d want 0/0", bid_count, ask_count);
        end
        n_total++;
        if (best_bid !== 32'd0 || best_ask !== 32'hffff_ffff) begin
            n_bad++; $display("FAIL reset_best got %h/%h want 0/ffffffff", best_bid, best_ask);
        end
        n_total++;
        if (ask_prices !== {128{1'b1}} || bid_prices !== 128'd0) begin
            n_bad++; $display("FAIL reset_ladders got bid=%h ask=%h", bid_prices, ask_prices);
        end
        n_total++;
        if (best_bid_qty !== 32'd0 || best_ask_qty !== 32'd0 || bid_qtys !== 128'd0) begin
            n_bad++; $display("FAIL reset_qty got %h/%h want 0/0", best_bid_qty, best_ask_qty);
        end
        n_total++;
        if (bbo_updated !== 1'b0 || drop_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_flags got bbo=%b drop=%0d want 0/0", bbo_updated, drop_count);
        end
        n_total++;
        if (tick_if.s_tick_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready got %b want 1", tick_if.s_tick_ready);
        end
    endtask

    task automatic test_bid_insert();
        logic p0, p1, p2;
        do_tick(32'd15000, 32'd100, 1'b1, 2'b00, p0);
        do_tick(32'd15010, 32'd50,  1'b1, 2'b00, p1);
        do_tick(32'd14990, 32'd20,  1'b1, 2'b00, p2);
        n_total++;
        if (bid_prices !== {32'd0, 32'd14990, 32'd15000, 32'd15010}) begin
            n_bad++; $display("FAIL bid_ins_prices got %h", bid_prices);
        end
        n_total++;
        if (bid_qtys !== {32'd0, 32'd20, 32'd100, 32'd50}) begin
            n_bad++; $display("FAIL bid_ins_qtys got %h", bid_qtys);
        end
        n_total++;
        if (bid_count !== 3'd3) begin
            n_bad++; $display("FAIL bid_ins_count got %0d want 3", bid_count);
        end
        n_total++;
        if ({p0, p1, p2} !== 3'b110) begin
            n_bad++; $display("FAIL bid_ins_pulses got %b want 110", {p0, p1, p2});
        end
    endtask

    task automatic test_ask_full();
        logic p;
        for (int i = 0; i < 4; i++) do_tick(32'(100 + i), 32'd1, 1'b0, 2'b00, p);
        do_tick(32'd99, 32'd7, 1'b0, 2'b00, p);
        n_total++;
        if (ask_prices !== {32'd102, 32'd101, 32'd100, 32'd99} ||
            ask_qtys !== {32'd1, 32'd1, 32'd1, 32'd7}) begin
            n_bad++; $display("FAIL ask_full_ladder got p=%h q=%h", ask_prices, ask_qtys);
        end
        n_total++;
        if (ask_count !== 3'd4 || best_ask !== 32'd99 || p !== 1'b1) begin
            n_bad++; $display("FAIL ask_full_best got cnt=%0d best=%0d pulse=%b want 4/99/1",
                              ask_count, best_ask, p);
        end
        do_tick(32'd200, 32'd1, 1'b0, 2'b00, p);
        n_total++;
        if (ask_prices !== {32'd102, 32'd101, 32'd100, 32'd99} || drop_count !== 16'd1 ||
            p !== 1'b0) begin
            n_bad++; $display("FAIL ask_worse_drop got p=%h drop=%0d pulse=%b want drop 1",
                              ask_prices, drop_count, p);
        end
    endtask

    task automatic test_reduce();
        logic p_clr, p_clr2, p;
        do_tick(32'd0, 32'd0, 1'b1, 2'b10, p_clr);
        do_tick(32'd0, 32'd0, 1'b1, 2'b10, p_clr2);
        n_total++;
        if (p_clr !== 1'b1 || p_clr2 !== 1'b0 || bid_count !== 3'd0 || bid_prices !== 128'd0) begin
            n_bad++; $display("FAIL clear_bid got pulses=%b%b cnt=%0d want 10/0",
                              p_clr, p_clr2, bid_count);
        end
        do_tick(32'd15000, 32'd100, 1'b1, 2'b00, p);
        do_tick(32'd15000, 32'd100, 1'b1, 2'b00, p);
        n_total++;
        if (bid_count !== 3'd1 || best_bid_qty !== 32'd200 || p !== 1'b1) begin
            n_bad++; $display("FAIL add_merge got cnt=%0d qty=%0d pulse=%b want 1/200/1",
                              bid_count, best_bid_qty, p);
        end
        do_tick(32'd15000, 32'd250, 1'b1, 2'b01, p);
        n_total++;
        if (bid_count !== 3'd0 || best_bid !== 32'd0 || best_bid_qty !== 32'd0 || p !== 1'b1) begin
            n_bad++; $display("FAIL reduce_remove got cnt=%0d best=%0d qty=%0d pulse=%b want 0/0/0/1",
                              bid_count, best_bid, best_bid_qty, p);
        end
    endtask

    task automatic test_saturate_and_drops();
        logic p, pa, pb, pc;
        do_tick(32'd300, 32'd5, 1'b1, 2'b00, p);
        do_tick(32'd300, 32'hffff_ffff, 1'b1, 2'b00, p);
        n_total++;
        if (best_bid_qty !== 32'hffff_ffff || p !== 1'b1) begin
            n_bad++; $display("FAIL qty_saturate got %h pulse=%b want ffffffff/1", best_bid_qty, p);
        end
        do_tick(32'd300, 32'd5, 1'b1, 2'b01, p);
        n_total++;
        if (best_bid_qty !== 32'hffff_fffa || bid_count !== 3'd1 || p !== 1'b1) begin
            n_bad++; $display("FAIL reduce_partial got %h cnt=%0d want fffffffa/1", best_bid_qty, bid_count);
        end
        do_tick(32'd777, 32'd1, 1'b1, 2'b01, pa);
        do_tick(32'd0,   32'd3, 1'b1, 2'b00, pb);
        do_tick(32'd300, 32'd1, 1'b1, 2'b11, pc);
        n_total++;
        if (drop_count !== 16'd4) begin
            n_bad++; $display("FAIL drop_count got %0d want 4", drop_count);
        end
        n_total++;
        if (best_bid !== 32'd300 || best_bid_qty !== 32'hffff_fffa || bid_count !== 3'd1 ||
            {pa, pb, pc} !== 3'b000) begin
            n_bad++; $display("FAIL drops_unchanged got best=%0d qty=%h cnt=%0d pulses=%b",
                              best_bid, best_bid_qty, bid_count, {pa, pb, pc});
        end
    endtask

    task automatic test_back_to_back();
        logic p;
        logic [31:0] prices [3];
        logic [31:0] qtys   [3];
        int acc, exp_cnt;
        int acc_edge [3];
        logic rdy;
        prices = '{32'd50, 32'd60, 32'd40};
        qtys   = '{32'd1, 32'd2, 32'd3};
        do_tick(32'd0, 32'd0, 1'b0, 2'b10, p);
        acc = 0;
        tick_if.s_tick_price  = prices[0];
        tick_if.s_tick_qty    = qtys[0];
        tick_if.s_tick_is_buy = 1'b0;
        tick_if.s_tick_op     = 2'b00;
        tick_if.s_tick_valid  = 1'b1;
        for (int c = 0; c < 9; c++) begin
            rdy = tick_if.s_tick_ready;
            n_total++;
            if (rdy !== (c % 3 == 0)) begin
                n_bad++; $display("FAIL b2b_ready cycle %0d got %b want %b", c, rdy, (c % 3 == 0));
            end
            @(posedge clk); #1;
            if (rdy === 1'b1 && acc < 3) begin
                acc_edge[acc] = c;
                acc++;
                if (acc < 3) begin
                    tick_if.s_tick_price = prices[acc];
                    tick_if.s_tick_qty   = qtys[acc];
                end
            end
            exp_cnt = 0;
            for (int k = 0; k < acc; k++) if (acc_edge[k] <= c - 2) exp_cnt++;
            n_total++;
            if (ask_count !== 3'(exp_cnt)) begin
                n_bad++; $display("FAIL b2b_count cycle %0d got %0d want %0d", c, ask_count, exp_cnt);
            end
        end
        tick_if.s_tick_valid = 1'b0;
        n_total++;
        if (acc != 3 || ask_prices !== {32'hffff_ffff, 32'd60, 32'd50, 32'd40} ||
            ask_qtys !== {32'd0, 32'd2, 32'd1, 32'd3}) begin
            n_bad++; $display("FAIL b2b_ladder got acc=%0d p=%h q=%h", acc, ask_prices, ask_qtys);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_pulse;
        tick_if.s_tick_price  = 32'd500;
        tick_if.s_tick_qty    = 32'd1;
        tick_if.s_tick_is_buy = 1'b1;
        tick_if.s_tick_op     = 2'b00;
        tick_if.s_tick_valid  = 1'b1;
        @(posedge clk); #1;
        tick_if.s_tick_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        n_total++;
        if (bid_count !== 3'd0 || ask_count !== 3'd0 || best_bid !== 32'd0 ||
            best_ask !== 32'hffff_ffff || drop_count !== 16'd0) begin
            n_bad++; $display("FAIL mid_reset_values got bc=%0d ac=%0d bb=%0d ba=%h drop=%0d",
                              bid_count, ask_count, best_bid, best_ask, drop_count);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        seen_pulse = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bbo_updated === 1'b1) seen_pulse = 1'b1;
        end
        n_total++;
        if (seen_pulse !== 1'b0 || bid_count !== 3'd0 || bid_prices !== 128'd0 ||
            tick_if.s_tick_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_reset_after got pulse=%b cnt=%0d ready=%b want 0/0/1",
                              seen_pulse, bid_count, tick_if.s_tick_ready);
        end
    endtask

    initial begin
        rst_n                 = 1'b0;
        tick_if.s_tick_price  = '0;
        tick_if.s_tick_qty    = '0;
        tick_if.s_tick_is_buy = 1'b0;
        tick_if.s_tick_op     = 2'b00;
        tick_if.s_tick_valid  = 1'b0;
        #23;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_bid_insert();
        test_ask_full();
        test_reduce();
        test_saturate_and_drops();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
